mod9_seq_checker: RTL and testbench



---
 rtl/mod9_seq_checker_if.sv | 22 ++
 rtl/mod9_seq_checker.sv | 109 ++++++++++
 tb/tb_mod9_seq_checker.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mod9_seq_checker_if.sv
// mod9_seq_checker_if: sampled count stream in, lock/error/wrap status out
interface mod9_seq_checker_if #(
  parameter int W     = 5,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic [W-1:0]     in_count;
  logic             locked;
  logic             err_pulse;
  logic             wrap_pulse;
  logic [W-1:0]     expected;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] wrap_count;
  modport master (
    output in_valid, in_count,
    input  locked, err_pulse, wrap_pulse, expected, err_count, wrap_count
  );
  modport slave (
    input  in_valid, in_count,
    output locked, err_pulse, wrap_pulse, expected, err_count, wrap_count
  );
endinterface

// File: rtl/mod9_seq_checker.sv
// mod9_seq_checker: locks onto a 0..MOD-1 increment stream and flags/counts breaks and wraps
module mod9_seq_checker #(
  parameter int MOD        = 9,
  parameter int W          = 5,
  parameter int LOCK_COUNT = 3,
  parameter int CNT_W      = 8
) (
  input logic              clk,
  input logic              rst,
  mod9_seq_checker_if.slave bus
);
  localparam int SW = $clog2(LOCK_COUNT + 1);
  typedef enum logic {SEARCH, LOCKED} state_t;
  state_t           state_q, state_d;
  logic [SW-1:0]    streak_q, streak_d;
  logic             have_last_q, have_last_d;
  logic [W-1:0]     last_q, last_d;
  logic [W-1:0]     expected_q, expected_d;
  logic             err_pulse_q, err_pulse_d;
  logic             wrap_pulse_q, wrap_pulse_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [CNT_W-1:0] wrap_count_q, wrap_count_d;
  logic [W-1:0]     v, v_succ;
  logic             oor;
  function automatic logic [W-1:0] succ(input logic [W-1:0] x);
    return (x == W'(MOD - 1)) ? '0 : x + 1'b1;
  endfunction
  assign v      = bus.in_count;
  assign v_succ = succ(v);
  assign oor    = v >= W'(MOD);
  always_comb begin
    state_d      = state_q;
    streak_d     = streak_q;
    have_last_d  = have_last_q;
    last_d       = last_q;
    expected_d   = expected_q;
    err_count_d  = err_count_q;
    wrap_count_d = wrap_count_q;
    err_pulse_d  = 1'b0;
    wrap_pulse_d = 1'b0;
    if (bus.in_valid && state_q == SEARCH) begin
      if (oor) begin
        streak_d    = '0;
        have_last_d = 1'b0;
      end else if (!have_last_q) begin
        have_last_d = 1'b1;
        last_d      = v;
        streak_d    = '0;
      end else if (v == succ(last_q)) begin
        last_d = v;
        if (streak_q + 1'b1 == SW'(LOCK_COUNT)) begin
          state_d    = LOCKED;
          expected_d = v_succ;
          streak_d   = '0;
        end else begin
          streak_d = streak_q + 1'b1;
        end
      end else begin
        last_d   = v;
        streak_d = '0;
      end
    end else if (bus.in_valid) begin
      if (v == expected_q) begin
        expected_d   = v_succ;
        last_d       = v;
        wrap_pulse_d = v == '0;
        wrap_count_d = (v == '0) ? wrap_count_q + 1'b1 : wrap_count_q;
      end else begin
        // any break drops lock; an in-range sample immediately seeds the new search
        err_pulse_d = 1'b1;
        err_count_d = (&err_count_q) ? err_count_q : err_count_q + 1'b1;
        state_d     = SEARCH;
        expected_d  = '0;
        streak_d    = '0;
        have_last_d = !oor;
        last_d      = oor ? last_q : v;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SEARCH;
      streak_q     <= '0;
      have_last_q  <= 1'b0;
      last_q       <= '0;
      expected_q   <= '0;
      err_pulse_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
      err_count_q  <= '0;
      wrap_count_q <= '0;
    end else begin
      state_q      <= state_d;
      streak_q     <= streak_d;
      have_last_q  <= have_last_d;
      last_q       <= last_d;
      expected_q   <= expected_d;
      err_pulse_q  <= err_pulse_d;
      wrap_pulse_q <= wrap_pulse_d;
      err_count_q  <= err_count_d;
      wrap_count_q <= wrap_count_d;
    end
  end
  assign bus.locked     = state_q == LOCKED;
  assign bus.err_pulse  = err_pulse_q;
  assign bus.wrap_pulse = wrap_pulse_q;
  assign bus.expected   = expected_q;
  assign bus.err_count  = err_count_q;
  assign bus.wrap_count = wrap_count_q;
endmodule

// File: tb/tb_mod9_seq_checker.sv
// tb_mod9_seq_checker: directed scenarios plus random stream checked against a rule-level model
module tb_mod9_seq_checker;
  localparam int MOD = 9, W = 5, LC = 3, CW = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0, errors = 0;
  bit m_locked, m_have, m_ep, m_wp;
  int m_last, m_streak, m_exp, m_err, m_wrap;
  mod9_seq_checker_if #(.W(W), .CNT_W(CW)) bus ();
  mod9_seq_checker #(.MOD(MOD), .W(W), .LOCK_COUNT(LC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    {m_locked, m_have, m_ep, m_wp} = '0;
    {m_last, m_streak, m_exp, m_err, m_wrap} = '0;
  endtask
  task automatic model_step(input bit valid, input int c);
    m_ep = 0;
    m_wp = 0;
    if (!valid) return;
    if (m_locked) begin
      if (c == m_exp) begin
        m_exp = (c + 1) % MOD;
        if (c == 0) begin m_wp = 1; m_wrap = (m_wrap + 1) % 256; end
      end else begin
        m_ep = 1;
        m_err = (m_err < 255) ? m_err + 1 : 255;
        m_locked = 0;
        m_exp = 0;
        m_streak = 0;
        m_have = c < MOD;
        m_last = c;
      end
    end else if (c >= MOD) begin
      m_streak = 0;
      m_have = 0;
    end else if (m_have && c == (m_last + 1) % MOD) begin
      m_last = c;
      m_streak++;
      if (m_streak == LC) begin
        m_locked = 1;
        m_exp = (c + 1) % MOD;
        m_streak = 0;
      end
    end else begin
      m_have = 1;
      m_last = c;
      m_streak = 0;
    end
  endtask
  task automatic cyc(input bit valid, input int c);
    bus.in_valid = valid;
    bus.in_count = W'(c);
    @(posedge clk);
    if (rst) model_reset();
    else model_step(valid, c);
    #1;
    chk("locked", bus.locked, m_locked);
    chk("err_pulse", bus.err_pulse, m_ep);
    chk("wrap_pulse", bus.wrap_pulse, m_wp);
    chk("expected", bus.expected, m_exp);
    chk("err_count", bus.err_count, m_err);
    chk("wrap_count", bus.wrap_count, m_wrap);
  endtask
  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) cyc(1'b1, $urandom_range(0, 31));
    rst = 1'b0;
  endtask
  initial begin
    int g;
    bus.in_valid = 1'b0;
    bus.in_count = '0;
    do_reset(2);
    chk("t1_reset_locked", bus.locked, 0);
    // 1: free-running stream locks after 0,1,2,3
    for (int i = 0; i < 4; i++) cyc(1, i);
    chk("t1_locked", bus.locked, 1);
    chk("t1_expected", bus.expected, 4);
    // 2: wrap
    for (int i = 4; i < 9; i++) cyc(1, i);
    cyc(1, 0);
    chk("t2_wrap_pulse", bus.wrap_pulse, 1);
    chk("t2_wrap_count", bus.wrap_count, 1);
    chk("t2_err_count", bus.err_count, 0);
    // 3: error at expected=5 then relock
    for (int i = 1; i < 5; i++) cyc(1, i);
    chk("t3_exp5", bus.expected, 5);
    cyc(1, 6);
    chk("t3_err_pulse", bus.err_pulse, 1);
    chk("t3_err_count", bus.err_count, 1);
    chk("t3_unlocked", bus.locked, 0);
    cyc(1, 7); cyc(1, 8);
    chk("t3_pulse_gone", bus.err_pulse, 0);
    cyc(1, 0);
    chk("t3_relocked", bus.locked, 1);
    chk("t3_relock_exp", bus.expected, 1);
    // 4: out-of-range break
    cyc(1, 1); cyc(1, 2); cyc(1, 12);
    chk("t4_err_pulse", bus.err_pulse, 1);
    chk("t4_unlocked", bus.locked, 0);
    for (int i = 3; i < 7; i++) cyc(1, i);
    chk("t4_locked", bus.locked, 1);
    chk("t4_expected", bus.expected, 7);
    // 5: gapped stream
    do_reset(1);
    for (int i = 2; i < 6; i++) begin
      cyc(1, i);
      cyc(0, $urandom_range(0, 31));
      chk("t5_no_err", bus.err_pulse, 0);
      chk("t5_no_wrap", bus.wrap_pulse, 0);
    end
    chk("t5_locked", bus.locked, 1);
    chk("t5_expected", bus.expected, 6);
    // 6: error count saturation, reset while locked
    do_reset(1);
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < 4; i++) cyc(1, i);
      cyc(1, 0);
    end
    chk("t6_err_sat", bus.err_count, 255);
    for (int i = 1; i < 5; i++) cyc(1, i);
    chk("t6_locked_before_rst", bus.locked, 1);
    do_reset(1);
    chk("t6_rst_locked", bus.locked, 0);
    chk("t6_rst_err", bus.err_count, 0);
    chk("t6_rst_exp", bus.expected, 0);
    // random: mostly-correct counter stream with glitches, stalls and gaps
    g = 0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 3) == 0) cyc(0, $urandom_range(0, 31));
      else if ($urandom_range(0, 19) == 0) cyc(1, $urandom_range(0, 31));
      else if ($urandom_range(0, 29) == 0) cyc(1, (g + MOD - 1) % MOD);
      else begin
        cyc(1, g);
        g = (g + 1) % MOD;
      end
      if (n == 2000) do_reset(1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
